// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the unified instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // Round-robin pick: a lone requester wins; on a tie the side not served last wins.
  function automatic grant_e arb_pick(logic i_req, logic d_req, grant_e last);
    if (d_req && !i_req) return GRANT_D;
    if (i_req && !d_req) return GRANT_I;
    return (last == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request/response and memory-side command bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_ready;

  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;

  logic                 m_readM;
  logic                 m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;

  // Arbiter view.
  modport slave (
    input  i_req, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_readM, m_writeM, m_address, m_wdata
  );

  // Requester + memory view.
  modport master (
    output i_req, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_readM, m_writeM, m_address, m_wdata
  );
endinterface

// File: rtl/mem_arbiter_latency_counter.sv
// Down-counter tracking the fixed memory latency; reloaded on every grant.
module mem_arbiter_latency_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset_N,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  // Counter register.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch (I) and data (D) requesters.
// One access at a time: IDLE -> BUSY (MEM_LATENCY cycles) -> DONE (ready pulse).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic         Clk,
  input  logic         Reset_N,
  mem_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

  arb_state_e           state_q, state_d;
  grant_e               owner_q, owner_d;
  grant_e               last_q, last_d;
  grant_e               pick;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 wr_q, wr_d;
  logic                 d_req, busy, cnt_load, cnt_zero;

  assign d_req = bus.d_readM | bus.d_writeM;
  assign busy  = (state_q == ARB_BUSY);

  mem_arbiter_latency_counter #(.W(CNT_W)) u_cnt (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .load_i     (cnt_load),
    .dec_i      (busy),
    .load_val_i (LOAD_VAL),
    .zero_o     (cnt_zero)
  );

  // Next state: grant/latch in IDLE, capture read data at end of BUSY, DONE always returns.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_load  = 1'b0;
    pick      = arb_pick(bus.i_req, d_req, last_q);
    case (state_q)
      ARB_IDLE: begin
        if (bus.i_req || d_req) begin
          state_d  = ARB_BUSY;
          owner_d  = pick;
          last_d   = pick;
          cnt_load = 1'b1;
          if (pick == GRANT_D) begin
            addr_d  = bus.d_address;
            wdata_d = bus.d_wdata;
            wr_d    = bus.d_writeM;  // write wins if both ops are (illegally) set
          end else begin
            addr_d  = bus.i_address;
            wdata_d = '0;
            wr_d    = 1'b0;
          end
        end
      end
      ARB_BUSY: begin
        if (cnt_zero) begin
          state_d = ARB_DONE;
          if (!wr_q) begin
            if (owner_q == GRANT_D) d_rdata_d = bus.m_rdata;
            else                    i_rdata_d = bus.m_rdata;
          end
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= ARB_IDLE;
      owner_q   <= GRANT_I;
      last_q    <= GRANT_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Memory commands come only from latched state, so requester changes mid-access are ignored.
  assign bus.m_readM   = busy & ~wr_q;
  assign bus.m_writeM  = busy & wr_q;
  assign bus.m_address = busy ? addr_q : '0;
  assign bus.m_wdata   = (busy && wr_q) ? wdata_q : '0;

  assign bus.i_ready   = (state_q == ARB_DONE) && (owner_q == GRANT_I);
  assign bus.d_ready   = (state_q == ARB_DONE) && (owner_q == GRANT_D);
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LATENCY=2 main instance plus a MEM_LATENCY=1 instance.
module tb_mem_arbiter;
  logic Clk = 1'b0;
  logic Reset_N = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  mem_arbiter_if #(.WORD_SIZE(16)) bus0 ();
  mem_arbiter_if #(.WORD_SIZE(16)) bus1 ();

  mem_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2)) dut0 (.Clk(Clk), .Reset_N(Reset_N), .bus(bus0));
  mem_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(1)) dut1 (.Clk(Clk), .Reset_N(Reset_N), .bus(bus1));

  // Memory model for dut0: fixed contents unless written; read data valid only
  // from the second consecutive read cycle (latency 2), garbage before that.
  logic [15:0]  wmem [0:255];
  logic [255:0] wvalid = '0;
  int           rd_run = 0;

  function automatic logic [15:0] rom(logic [15:0] a);
    case (a)
      16'h0010: return 16'h1234;
      16'h0030: return 16'h5555;
      16'h0040: return 16'h7777;
      16'h0099: return 16'h9999;
      default:  return a ^ 16'hFFFF;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (bus0.m_writeM) begin
      wmem[bus0.m_address[7:0]]   <= bus0.m_wdata;
      wvalid[bus0.m_address[7:0]] <= 1'b1;
    end
    rd_run <= bus0.m_readM ? rd_run + 1 : 0;
  end

  assign bus0.m_rdata = (bus0.m_readM && rd_run >= 1) ?
                        (wvalid[bus0.m_address[7:0]] ? wmem[bus0.m_address[7:0]] : rom(bus0.m_address)) :
                        16'hDEAD;

  // Latency-1 memory for dut1: data is a fixed function of address, valid immediately.
  assign bus1.m_rdata = bus1.m_readM ? (bus1.m_address ^ 16'hA5A5) : 16'h0000;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    bus0.i_req = 0; bus0.i_address = 0; bus0.d_readM = 0; bus0.d_writeM = 0;
    bus0.d_address = 0; bus0.d_wdata = 0;
    bus1.i_req = 0; bus1.i_address = 0; bus1.d_readM = 0; bus1.d_writeM = 0;
    bus1.d_address = 0; bus1.d_wdata = 0;
    Reset_N = 0;
    #12;
    total++; if ({bus0.i_ready, bus0.d_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {bus0.i_ready, bus0.d_ready}); end
    total++; if ({bus0.m_readM, bus0.m_writeM} !== 2'b00) begin bad++; $display("FAIL reset_cmd got=%b want=00", {bus0.m_readM, bus0.m_writeM}); end
    total++; if (bus0.m_address !== 16'h0) begin bad++; $display("FAIL reset_maddr got=%h want=0000", bus0.m_address); end
    total++; if ({bus0.i_rdata, bus0.d_rdata} !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", {bus0.i_rdata, bus0.d_rdata}); end
    tick();
    Reset_N = 1;
    tick();
    total++; if (bus0.m_readM !== 1'b0) begin bad++; $display("FAIL idle_noreq got=%b want=0", bus0.m_readM); end
  endtask

  task automatic test_lone_fetch();
    bus0.i_req = 1; bus0.i_address = 16'h0010;
    tick();
    total++; if (bus0.m_readM !== 1'b1 || bus0.m_address !== 16'h0010) begin bad++; $display("FAIL fetch_c1 got=%b/%h want=1/0010", bus0.m_readM, bus0.m_address); end
    total++; if (bus0.i_ready !== 1'b0) begin bad++; $display("FAIL fetch_early_rdy got=%b want=0", bus0.i_ready); end
    tick();
    total++; if (bus0.m_readM !== 1'b1 || bus0.i_ready !== 1'b0) begin bad++; $display("FAIL fetch_c2 got=%b/%b want=1/0", bus0.m_readM, bus0.i_ready); end
    tick();
    total++; if (bus0.i_ready !== 1'b1 || bus0.i_rdata !== 16'h1234) begin bad++; $display("FAIL fetch_done got=%b/%h want=1/1234", bus0.i_ready, bus0.i_rdata); end
    total++; if (bus0.d_ready !== 1'b0 || bus0.m_readM !== 1'b0) begin bad++; $display("FAIL fetch_done_side got=%b/%b want=0/0", bus0.d_ready, bus0.m_readM); end
    bus0.i_req = 0;
    tick();
    total++; if (bus0.i_ready !== 1'b0 || bus0.i_rdata !== 16'h1234) begin bad++; $display("FAIL fetch_hold got=%b/%h want=0/1234", bus0.i_ready, bus0.i_rdata); end
  endtask

  task automatic test_lone_write();
    bus0.d_writeM = 1; bus0.d_address = 16'h0020; bus0.d_wdata = 16'hBEEF;
    tick();
    total++; if ({bus0.m_writeM, bus0.m_readM} !== 2'b10 || bus0.m_wdata !== 16'hBEEF || bus0.m_address !== 16'h0020) begin
      bad++; $display("FAIL write_c1 got=%b/%h/%h want=10/beef/0020", {bus0.m_writeM, bus0.m_readM}, bus0.m_wdata, bus0.m_address); end
    tick();
    total++; if (bus0.m_writeM !== 1'b1 || bus0.d_ready !== 1'b0) begin bad++; $display("FAIL write_c2 got=%b/%b want=1/0", bus0.m_writeM, bus0.d_ready); end
    tick();
    total++; if (bus0.d_ready !== 1'b1 || bus0.m_writeM !== 1'b0 || bus0.i_ready !== 1'b0) begin
      bad++; $display("FAIL write_done got=%b/%b/%b want=1/0/0", bus0.d_ready, bus0.m_writeM, bus0.i_ready); end
    total++; if (bus0.d_rdata !== 16'h0000) begin bad++; $display("FAIL write_rdata_kept got=%h want=0000", bus0.d_rdata); end
    bus0.d_writeM = 0;
    tick();
    bus0.d_readM = 1;
    tick(); tick(); tick();
    total++; if (bus0.d_ready !== 1'b1 || bus0.d_rdata !== 16'hBEEF) begin bad++; $display("FAIL readback got=%b/%h want=1/beef", bus0.d_ready, bus0.d_rdata); end
    bus0.d_readM = 0;
    tick();
  endtask

  task automatic test_tie();
    Reset_N = 0;
    tick();
    Reset_N = 1;
    bus0.i_req = 1; bus0.i_address = 16'h0040;
    bus0.d_readM = 1; bus0.d_address = 16'h0030;
    tick();
    total++; if (bus0.m_address !== 16'h0030) begin bad++; $display("FAIL tie_first_addr got=%h want=0030", bus0.m_address); end
    tick(); tick();
    total++; if ({bus0.d_ready, bus0.i_ready} !== 2'b10 || bus0.d_rdata !== 16'h5555) begin
      bad++; $display("FAIL tie_d_first got=%b/%h want=10/5555", {bus0.d_ready, bus0.i_ready}, bus0.d_rdata); end
    tick();
    total++; if ({bus0.d_ready, bus0.i_ready} !== 2'b00) begin bad++; $display("FAIL tie_gap got=%b want=00", {bus0.d_ready, bus0.i_ready}); end
    tick();
    total++; if (bus0.m_address !== 16'h0040) begin bad++; $display("FAIL tie_second_addr got=%h want=0040", bus0.m_address); end
    tick(); tick();
    total++; if ({bus0.d_ready, bus0.i_ready} !== 2'b01 || bus0.i_rdata !== 16'h7777) begin
      bad++; $display("FAIL tie_i_second got=%b/%h want=01/7777", {bus0.d_ready, bus0.i_ready}, bus0.i_rdata); end
    tick(); tick();
    total++; if (bus0.m_address !== 16'h0030) begin bad++; $display("FAIL tie_third_addr got=%h want=0030", bus0.m_address); end
    tick(); tick();
    total++; if ({bus0.d_ready, bus0.i_ready} !== 2'b10) begin bad++; $display("FAIL tie_alternate got=%b want=10", {bus0.d_ready, bus0.i_ready}); end
    bus0.i_req = 0; bus0.d_readM = 0;
    tick();
  endtask

  task automatic test_stability();
    bus0.i_req = 1; bus0.i_address = 16'h0010;
    tick();
    bus0.i_address = 16'h0099;
    tick();
    total++; if (bus0.m_address !== 16'h0010) begin bad++; $display("FAIL stable_addr got=%h want=0010", bus0.m_address); end
    tick();
    total++; if (bus0.i_ready !== 1'b1 || bus0.i_rdata !== 16'h1234) begin bad++; $display("FAIL stable_data got=%b/%h want=1/1234", bus0.i_ready, bus0.i_rdata); end
    bus0.i_req = 0;
    tick();
  endtask

  task automatic test_async_reset();
    bus0.i_req = 1; bus0.i_address = 16'h0040;
    tick();
    total++; if (bus0.m_readM !== 1'b1) begin bad++; $display("FAIL ar_busy got=%b want=1", bus0.m_readM); end
    #3 Reset_N = 0;
    #1;
    total++; if ({bus0.m_readM, bus0.i_ready} !== 2'b00 || bus0.m_address !== 16'h0 || bus0.i_rdata !== 16'h0) begin
      bad++; $display("FAIL ar_immediate got=%b/%h/%h want=00/0000/0000", {bus0.m_readM, bus0.i_ready}, bus0.m_address, bus0.i_rdata); end
    tick();
    total++; if (bus0.i_ready !== 1'b0) begin bad++; $display("FAIL ar_no_pulse got=%b want=0", bus0.i_ready); end
    Reset_N = 1;
    tick();
    total++; if (bus0.m_readM !== 1'b1 || bus0.i_ready !== 1'b0) begin bad++; $display("FAIL ar_regrant got=%b/%b want=1/0", bus0.m_readM, bus0.i_ready); end
    tick(); tick();
    total++; if (bus0.i_ready !== 1'b1 || bus0.i_rdata !== 16'h7777) begin bad++; $display("FAIL ar_reserved got=%b/%h want=1/7777", bus0.i_ready, bus0.i_rdata); end
    bus0.i_req = 0;
    tick();
  endtask

  task automatic test_lat1();
    logic [5:0] exp_rdy;
    exp_rdy = 6'b010010;  // bit k-1 = ready expected after tick k
    bus1.i_req = 1; bus1.i_address = 16'h0100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (bus1.i_ready !== exp_rdy[k-1]) begin bad++; $display("FAIL lat1_rdy t=%0d got=%b want=%b", k, bus1.i_ready, exp_rdy[k-1]); end
      if (k == 1) begin
        total++; if (bus1.m_address !== 16'h0100) begin bad++; $display("FAIL lat1_addr got=%h want=0100", bus1.m_address); end
      end
      if (k == 2) begin
        total++; if (bus1.i_rdata !== 16'hA4A5) begin bad++; $display("FAIL lat1_data1 got=%h want=a4a5", bus1.i_rdata); end
        bus1.i_address = 16'h0200;
      end
      if (k == 5) begin
        total++; if (bus1.i_rdata !== 16'hA7A5) begin bad++; $display("FAIL lat1_data2 got=%h want=a7a5", bus1.i_rdata); end
      end
    end
    bus1.i_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_lone_write();
    test_tie();
    test_stability();
    test_async_reset();
    test_lat1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
